// File: rtl/xbar_port_scheduler.sv
// xbar_port_scheduler: shares one crossbar output port between four input
// requesters. Arbitration is round-robin at packet granularity: the winner
// keeps the grant until its last beat is accepted. Beats pass through one
// registered valid/ready stage to the output link.
module xbar_port_scheduler #(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          in_valid,
    input  logic [3:0]          in_last,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    output logic                out_last,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_src,
    input  logic                out_ready,
    output logic                busy,
    output logic                len_err
);

    // Wide enough to hold MAX_BEATS itself, where the counter saturates.
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [1:0]          rr_ptr_q,    rr_ptr_d;
    logic [1:0]          sel_q,       sel_d;
    logic [CNT_W-1:0]    beat_cnt_q,  beat_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q,  out_last_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [1:0]          out_src_q,   out_src_d;
    logic                len_err_q,   len_err_d;

    logic [DATA_W-1:0]   req_data [4];
    logic [1:0]          winner;
    logic [1:0]          rr_idx;
    logic                sel_ready;
    logic                accept;

    // Split the flat payload bus into one word per requester.
    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign req_data[i] = in_data[i*DATA_W +: DATA_W];
    end

    // Round-robin pick: scanning from the far end down lets the valid
    // requester closest to rr_ptr_q be the one that sticks.
    always_comb begin
        winner = rr_ptr_q;
        rr_idx = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            rr_idx = rr_ptr_q + 2'(k);
            if (in_valid[rr_idx]) begin
                winner = rr_idx;
            end
        end
    end

    // Next-state, grant and output-register load logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        sel_d       = sel_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        len_err_d   = len_err_q;
        in_ready    = 4'b0000;
        sel_ready   = !out_valid_q || out_ready;
        accept      = 1'b0;

        // The output stage drains on its own, independent of the grant.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    sel_d      = winner;
                    state_d    = XFER;
                    beat_cnt_d = '0;
                end
            end
            XFER: begin
                in_ready[sel_q] = sel_ready;
                accept          = in_valid[sel_q] && sel_ready;
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = req_data[sel_q];
                    out_last_d  = in_last[sel_q];
                    out_src_d   = sel_q;
                    // Oversized packets still pass; the error is only flagged.
                    if (beat_cnt_q == CNT_W'(MAX_BEATS)) begin
                        len_err_d = 1'b1;
                    end
                    if (in_last[sel_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = sel_q + 2'd1;
                    end else if (beat_cnt_q != CNT_W'(MAX_BEATS)) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial packet.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd0;
            sel_q       <= 2'd0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sel_q       <= sel_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            len_err_q   <= len_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == XFER);
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_xbar_port_scheduler.sv
// tb_xbar_port_scheduler: directed, cycle-by-cycle bench for the output port
// scheduler. Inputs change 1 time unit after each rising edge; outputs are
// compared 1 time unit later, well clear of the edge.
module tb_xbar_port_scheduler;

    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic [3:0]          in_valid;
    logic [3:0]          in_last;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic                out_last;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_src;
    logic                out_ready;
    logic                busy;
    logic                len_err;

    int checks = 0;
    int errors = 0;

    xbar_port_scheduler #(
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy),
        .len_err   (len_err)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Safety net in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic set_beat(input int r, input logic [31:0] d, input logic last);
        in_data[r*DATA_W +: DATA_W] = d;
        in_last[r] = last;
    endtask

    // Leaves the bench at the start of the first cycle after reset.
    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 4'b0000;
        in_last   = 4'b0000;
        in_data   = '0;
        out_ready = 1'b1;
        adv();
        adv();
        reset = 1'b0;
    endtask

    logic [3:0] exp_rdy;

    initial begin
        // ---------------- reset state + single requester ----------------
        do_reset();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last",  out_last, 0);
        check("rst_out_data",  out_data, 0);
        check("rst_out_src",   out_src, 0);
        check("rst_in_ready",  in_ready, 0);
        check("rst_busy",      busy, 0);
        check("rst_len_err",   len_err, 0);
        check("rst_rr_ptr",    dut.rr_ptr_q, 0);
        // cycle 0: request from req1
        in_valid = 4'b0010; set_beat(1, 32'h0000_000A, 1'b0); #1;
        check("t1_c0_in_ready", in_ready, 4'b0000);
        adv();
        // cycle 1: granted
        #1;
        check("t1_c1_in_ready", in_ready, 4'b0010);
        check("t1_c1_busy", busy, 1);
        adv();
        // cycle 2: A on output
        set_beat(1, 32'h0000_000B, 1'b0); #1;
        check("t1_c2_out_valid", out_valid, 1);
        check("t1_c2_out_data", out_data, 32'h0000_000A);
        check("t1_c2_out_src", out_src, 1);
        check("t1_c2_out_last", out_last, 0);
        check("t1_c2_in_ready", in_ready, 4'b0010);
        adv();
        // cycle 3: B on output
        set_beat(1, 32'h0000_000C, 1'b1); #1;
        check("t1_c3_out_data", out_data, 32'h0000_000B);
        check("t1_c3_out_last", out_last, 0);
        adv();
        // cycle 4: C (last) on output, grant released
        in_valid = 4'b0000; #1;
        check("t1_c4_out_data", out_data, 32'h0000_000C);
        check("t1_c4_out_last", out_last, 1);
        check("t1_c4_out_src", out_src, 1);
        check("t1_c4_busy", busy, 0);
        check("t1_c4_rr_ptr", dut.rr_ptr_q, 2);
        check("t1_c4_in_ready", in_ready, 4'b0000);
        adv();
        #1;
        check("t1_c5_out_valid", out_valid, 0);

        // ---------------- round-robin fairness ----------------
        do_reset();
        in_valid = 4'b1111;
        for (int r = 0; r < 4; r++) set_beat(r, 32'hA0 + r, 1'b1);
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_rdy = (c % 2 == 1) ? 4'(1 << (((c - 1) / 2) % 4)) : 4'b0000;
            check("rr_in_ready", in_ready, exp_rdy);
            check("rr_onehot0", $onehot0(in_ready), 1);
            if (c >= 2) begin
                check("rr_out_valid", out_valid, (c % 2 == 0) ? 1 : 0);
                if (c % 2 == 0) begin
                    check("rr_out_src", out_src, ((c - 2) / 2) % 4);
                    check("rr_out_data", out_data, 32'hA0 + ((c - 2) / 2) % 4);
                end
            end
            adv();
        end

        // ---------------- packet lock ----------------
        do_reset();
        in_valid = 4'b0001; set_beat(0, 32'h0000_00D0, 1'b0); #1;
        check("lk_c0_in_ready", in_ready, 4'b0000);
        adv();
        in_valid = 4'b0101; set_beat(2, 32'h0000_00E0, 1'b1); #1;
        check("lk_c1_in_ready", in_ready, 4'b0001);
        adv();
        for (int k = 1; k <= 3; k++) begin
            set_beat(0, 32'h0000_00D0 + k, (k == 3)); #1;
            check("lk_in_ready", in_ready, 4'b0001);
            check("lk_out_data", out_data, 32'h0000_00D0 + k - 1);
            adv();
        end
        in_valid = 4'b0100; #1;
        check("lk_idle_in_ready", in_ready, 4'b0000);
        check("lk_idle_busy", busy, 0);
        check("lk_idle_out_data", out_data, 32'h0000_00D3);
        check("lk_idle_out_last", out_last, 1);
        adv();
        #1;
        check("lk_req2_in_ready", in_ready, 4'b0100);
        adv();
        in_valid = 4'b0000; #1;
        check("lk_req2_out_data", out_data, 32'h0000_00E0);
        check("lk_req2_out_src", out_src, 2);

        // ---------------- backpressure ----------------
        do_reset();
        in_valid = 4'b0010; set_beat(1, 32'h0000_00F0, 1'b0);
        adv();
        #1;
        check("bp_c1_in_ready", in_ready, 4'b0010);
        adv();
        set_beat(1, 32'h0000_00F1, 1'b0); #1;
        check("bp_c2_out_data", out_data, 32'h0000_00F0);
        adv();
        set_beat(1, 32'h0000_00F2, 1'b0); out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_hold_out_valid", out_valid, 1);
            check("bp_hold_out_data", out_data, 32'h0000_00F1);
            check("bp_hold_out_last", out_last, 0);
            check("bp_hold_out_src", out_src, 1);
            check("bp_hold_in_ready", in_ready, 4'b0000);
            adv();
        end
        out_ready = 1'b1; #1;
        check("bp_resume_in_ready", in_ready, 4'b0010);
        check("bp_resume_out_data", out_data, 32'h0000_00F1);
        adv();
        set_beat(1, 32'h0000_00F3, 1'b1); #1;
        check("bp_f2_out_data", out_data, 32'h0000_00F2);
        adv();
        in_valid = 4'b0000; #1;
        check("bp_f3_out_data", out_data, 32'h0000_00F3);
        check("bp_f3_out_last", out_last, 1);
        check("bp_f3_busy", busy, 0);
        adv();
        #1;
        check("bp_drain_out_valid", out_valid, 0);

        // ---------------- length error ----------------
        do_reset();
        in_valid = 4'b1000; set_beat(3, 32'h0000_0100, 1'b0);
        adv();
        for (int k = 1; k <= 17; k++) begin
            set_beat(3, 32'h0000_0100 + k, (k == 17)); #1;
            check("le_in_ready", in_ready, 4'b1000);
            check("le_len_err_low", len_err, 0);
            if (k >= 2) check("le_out_data", out_data, 32'h0000_0100 + k - 1);
            adv();
        end
        in_valid = 4'b0001; set_beat(0, 32'h0000_0200, 1'b0); #1;
        check("le_c18_len_err", len_err, 1);
        check("le_c18_out_data", out_data, 32'h0000_0111);
        check("le_c18_out_last", out_last, 1);
        check("le_c18_out_src", out_src, 3);
        check("le_c18_busy", busy, 0);
        adv();
        #1;
        check("le_c19_in_ready", in_ready, 4'b0001);
        adv();
        set_beat(0, 32'h0000_0201, 1'b1); #1;
        check("le_c20_out_data", out_data, 32'h0000_0200);
        check("le_c20_len_err", len_err, 1);
        adv();

        // ---------------- reset mid-packet ----------------
        in_valid = 4'b0101; set_beat(0, 32'h0000_0202, 1'b1);
        set_beat(2, 32'h0000_0300, 1'b0); #1;
        check("le_c21_out_data", out_data, 32'h0000_0201);
        check("le_c21_out_last", out_last, 1);
        check("le_c21_len_err", len_err, 1);
        check("le_c21_busy", busy, 0);
        adv();
        #1;
        check("rm_c22_in_ready", in_ready, 4'b0100);
        adv();
        set_beat(2, 32'h0000_0301, 1'b0); reset = 1'b1; #1;
        check("rm_c23_out_data", out_data, 32'h0000_0300);
        check("rm_c23_busy", busy, 1);
        adv();
        reset = 1'b0; in_valid = 4'b1000; set_beat(3, 32'h0000_0400, 1'b1); #1;
        check("rm_c24_out_valid", out_valid, 0);
        check("rm_c24_busy", busy, 0);
        check("rm_c24_in_ready", in_ready, 4'b0000);
        check("rm_c24_rr_ptr", dut.rr_ptr_q, 0);
        check("rm_c24_len_err", len_err, 0);
        check("rm_c24_out_data", out_data, 0);
        adv();
        #1;
        check("rm_c25_in_ready", in_ready, 4'b1000);
        adv();
        in_valid = 4'b0000; #1;
        check("rm_c26_out_valid", out_valid, 1);
        check("rm_c26_out_data", out_data, 32'h0000_0400);
        check("rm_c26_out_src", out_src, 3);
        check("rm_c26_out_last", out_last, 1);
        check("rm_c26_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_port_scheduler.md
Name: xbar_port_scheduler

Overview:
Per-output-port scheduler for the 4x4 crossbar. It shares one output port between 4 input requesters using packet-granular round-robin arbitration. The grant is held until the winner's last beat is accepted. Data passes through a single registered valid/ready stage to the output link. One instance sits in front of each crossbar output.

Parameters:
DATA_W, 32, payload width per beat
MAX_BEATS, 16, maximum legal beats per packet; longer packets raise len_err (power of 2, >=2)

Ports:
clock  input  1  system clock
reset  input  1  reset, synchronous, active-high
in_valid  input  4  per-requester beat valid
in_last  input  4  per-requester end-of-packet marker, qualified by in_valid
in_data  input  4*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
in_ready  output  4  per-requester beat accept; at most one bit high
out_valid  output  1  registered output beat valid
out_last  output  1  registered end-of-packet
out_data  output  DATA_W  registered payload
out_src  output  2  index of requester that sourced the current out beat
out_ready  input  1  downstream accept
busy  output  1  high while a packet is locked (state XFER)
len_err  output  1  sticky: some packet exceeded MAX_BEATS beats; cleared only by reset

Behaviour:
- Reset (sync, active-high) forces the following, and overrides any in-flight packet: state=IDLE, rr_ptr=0, sel=0, beat_cnt=0, out_valid=0, out_last=0, out_data=0, out_src=0, in_ready=0, busy=0, len_err=0. Partial packets are dropped.
- FSM states are IDLE and XFER.
- IDLE:
  - in_ready=0.
  - If any in_valid, pick the winner by round-robin: first i in order rr_ptr, rr_ptr+1, ... (mod 4) with in_valid[i]=1.
  - On the next edge: sel<=winner, state<=XFER, beat_cnt<=0.
  - If no in_valid, stay in IDLE.
- XFER:
  - in_ready[sel] = (!out_valid || out_ready). All other in_ready bits are 0.
  - Beat accepted when in_valid[sel] && in_ready[sel]. Output register then loads: out_data=in_data[sel], out_last=in_last[sel], out_src=sel, out_valid=1.
  - If out_ready && out_valid and no new beat is accepted, out_valid<=0.
  - Accepted beat with in_last=1: state<=IDLE, rr_ptr<=(sel+1) mod 4. The grant releases immediately; the output register drains independently.
  - Accepted beat with in_last=0: beat_cnt<=beat_cnt+1, saturating at MAX_BEATS.
  - If an accepted beat would be beat number MAX_BEATS+1 (beat_cnt==MAX_BEATS at acceptance): len_err<=1. The packet still passes and the lock is kept until in_last.
- Requests from non-selected requesters during XFER are ignored and not queued. Requesters hold in_valid until accepted.
- The selected requester dropping in_valid mid-packet simply stalls the port; the lock is held with no timeout.
- Latency: request at cycle 0 (IDLE) -> in_ready[sel]=1 in cycle 1 -> out_valid=1 in cycle 2.
- After a last beat there is exactly one IDLE bubble cycle before the next grant.
- Throughput is 1 beat/cycle while out_ready=1 (full-rate pass-through, no bubble within a packet).
- Output stability: while out_valid && !out_ready, out_data, out_last and out_src hold steady.
- rr_ptr advances only on packet completion, never on an individual beat.

Test Plan:
- Single requester: reset; req1 sends 3 beats (A,B,C, last on C), out_ready=1 -> in_ready=4'b0010 from cycle 1; out beats A,B,C in cycles 2-4 with out_src=1 and out_last only on C; rr_ptr=2; busy low in cycle 4.
- Round-robin fairness: all 4 requesters continuously send 1-beat packets -> grant order 0,1,2,3,0,...; each grant separated by one IDLE cycle; in_ready always one-hot or zero.
- Packet lock: req0 sends a 4-beat packet while req2 is valid from cycle 1 -> no in_ready[2] until req0's last beat is accepted; req2 is granted on the cycle after the following IDLE cycle.
- Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data/out_last/out_src hold; in_ready[sel]=0 once out_valid=1; no beats lost or duplicated after out_ready returns to 1.
- Length error: with MAX_BEATS=16, send a 17-beat packet -> len_err rises on acceptance of beat 17; all 17 beats are output; len_err stays 1 for subsequent legal packets until reset.
- Reset mid-packet: assert reset during beat 2 of a 5-beat packet -> next cycle out_valid=0, busy=0, in_ready=0, rr_ptr=0; a new request from req3 is then granted normally.
